spk_engine: RTL and testbench

Parametrised spike-processing engine for the SNN accelerator: converts per-neuron membrane potentials into spikes using hysteresis (spikability) and refractory tracking, accumulates per-neuron spike counts with an argmax winner for output-layer rate decoding, and assembles the input-layer spike frame from fixed-width chunks with a valid/ready handshake. It sits between the neuron-core potential outputs and the synapse/accumulate array, and serves the input, hidden and output layers from one instance.

---
 rtl/spk_engine_if.sv | 13 +
 rtl/spk_engine.sv | 142 ++++++++++++++
 tb/tb_spk_engine.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spk_engine_if.sv
// Input-chunk stream for the spike engine: valid/ready handshake plus a
// pointer-resync strobe.
interface spk_engine_if #(
  parameter int CHUNK_W = 128
);
  logic               in_valid;
  logic               in_ready;
  logic               in_sync;
  logic [CHUNK_W-1:0] in_data;

  modport master (output in_valid, in_sync, in_data, input in_ready);
  modport slave  (input in_valid, in_sync, in_data, output in_ready);
endinterface

// File: rtl/spk_engine.sv
// Spike engine: hysteresis/refractory spike generation, saturating per-neuron
// spike counters with a registered argmax winner, and input-frame assembly.
module spk_engine #(
  parameter int NUM_N   = 16,
  parameter int POT_W   = 8,
  parameter int THR_HI  = 64,
  parameter int THR_LO  = 0,
  parameter int REFRAC  = 2,
  parameter int CNT_W   = 8,
  parameter int CHUNK_W = 128,
  parameter int CHUNKS  = 8,
  localparam int WIN_W  = (NUM_N > 1) ? $clog2(NUM_N) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      step,
  input  logic [NUM_N*POT_W-1:0]    potential_in,
  output logic [NUM_N-1:0]          spk_out,
  output logic [NUM_N-1:0]          spkblty_out,
  input  logic                      cnt_clr,
  output logic [NUM_N*CNT_W-1:0]    cnt_out,
  output logic [WIN_W-1:0]          winner,
  spk_engine_if.slave               chunk_bus,
  output logic [CHUNK_W*CHUNKS-1:0] frame_out,
  output logic                      frame_valid
);

  localparam int RF_W  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int PTR_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic signed [POT_W-1:0] HI = POT_W'(THR_HI);
  localparam logic signed [POT_W-1:0] LO = POT_W'(THR_LO);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------- neuron evaluation ----------------
  logic [RF_W-1:0]  refrac [NUM_N];
  logic [NUM_N-1:0] fire, rearm;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path can leave it unassigned and infer a latch.
  always_comb begin
    logic signed [POT_W-1:0] pot;
    pot   = '0;
    fire  = '0;
    rearm = '0;
    for (int j = 0; j < NUM_N; j++) begin
      pot = potential_in[j*POT_W +: POT_W];
      if (step && refrac[j] == '0) begin
        fire[j]  = spkblty_out[j] && (pot >= HI);
        rearm[j] = !spkblty_out[j] && (pot <= LO);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      spk_out     <= '0;
      spkblty_out <= '1;
      for (int j = 0; j < NUM_N; j++) refrac[j] <= '0;
    end else begin
      spk_out     <= fire;
      spkblty_out <= (spkblty_out & ~fire) | rearm;
      if (step) begin
        for (int j = 0; j < NUM_N; j++) begin
          if (refrac[j] != '0)
            refrac[j] <= refrac[j] - RF_W'(1);
          else if (fire[j])
            refrac[j] <= RF_W'(REFRAC);
        end
      end
    end
  end

  // ---------------- counters and winner ----------------
  logic [WIN_W-1:0] best_idx;

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    logic [CNT_W-1:0] best_cnt;
    best_idx = '0;
    best_cnt = cnt_out[0 +: CNT_W];
    for (int j = 1; j < NUM_N; j++) begin
      if (cnt_out[j*CNT_W +: CNT_W] > best_cnt) begin
        best_cnt = cnt_out[j*CNT_W +: CNT_W];
        best_idx = WIN_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt_out <= '0;
      winner  <= '0;
    end else begin
      winner <= best_idx;
      for (int j = 0; j < NUM_N; j++)
        if (fire[j] && cnt_out[j*CNT_W +: CNT_W] != CNT_MAX)
          cnt_out[j*CNT_W +: CNT_W] <= cnt_out[j*CNT_W +: CNT_W] + CNT_W'(1);
    end
  end

  // ---------------- input frame loader ----------------
  logic [PTR_W-1:0]          ptr, slot;
  logic [CHUNK_W*CHUNKS-1:0] shadow, shadow_nxt;
  logic                      xfer, last;

  assign chunk_bus.in_ready = !reset;
  assign xfer = chunk_bus.in_valid && chunk_bus.in_ready;
  assign slot = chunk_bus.in_sync ? '0 : ptr;
  assign last = xfer && (slot == PTR_W'(CHUNKS - 1));

  always_comb begin
    shadow_nxt = shadow;
    for (int k = 0; k < CHUNKS; k++)
      if (xfer && slot == PTR_W'(k))
        shadow_nxt[k*CHUNK_W +: CHUNK_W] = chunk_bus.in_data;
  end

  // NOTE: the shadow buffer is reset explicitly so a frame interrupted by
  // reset can never leak stale chunks into a later commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      shadow      <= '0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
    end else begin
      shadow      <= shadow_nxt;
      frame_valid <= last;
      if (last) begin
        frame_out <= shadow_nxt;
        ptr       <= '0;
      end else if (xfer) begin
        ptr <= slot + PTR_W'(1);
      end else if (chunk_bus.in_sync) begin
        ptr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spk_engine.sv
// Self-checking bench for spk_engine: spec-level reference model compared every
// cycle, plus directed literal expectations for the listed scenarios.
module tb_spk_engine;
  localparam int NUM_N = 16, POT_W = 8, THR_HI = 64, THR_LO = 0, REFRAC = 2;
  localparam int CNT_W = 8, CHUNK_W = 128, CHUNKS = 8;

  logic clk = 1'b0, reset = 1'b1, step = 1'b0, cnt_clr = 1'b0;
  logic signed [POT_W-1:0]    pot [NUM_N];
  logic [NUM_N*POT_W-1:0]     potential_in;
  logic [NUM_N-1:0]           spk_out, spkblty_out;
  logic [NUM_N*CNT_W-1:0]     cnt_out;
  logic [3:0]                 winner;
  logic [CHUNK_W*CHUNKS-1:0]  frame_out;
  logic                       frame_valid;

  spk_engine_if #(.CHUNK_W(CHUNK_W)) bus ();

  spk_engine #(
    .NUM_N(NUM_N), .POT_W(POT_W), .THR_HI(THR_HI), .THR_LO(THR_LO),
    .REFRAC(REFRAC), .CNT_W(CNT_W), .CHUNK_W(CHUNK_W), .CHUNKS(CHUNKS)
  ) dut (
    .clk(clk), .reset(reset), .step(step), .potential_in(potential_in),
    .spk_out(spk_out), .spkblty_out(spkblty_out), .cnt_clr(cnt_clr),
    .cnt_out(cnt_out), .winner(winner), .chunk_bus(bus),
    .frame_out(frame_out), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    potential_in = '0;
    for (int j = 0; j < NUM_N; j++) potential_in[j*POT_W +: POT_W] = pot[j];
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  bit               started = 0;
  logic [NUM_N-1:0] m_spk, m_armed;
  int               m_rf [NUM_N];
  int               m_cnt [NUM_N];
  int               m_win;
  logic [CHUNK_W-1:0] m_slot [CHUNKS];
  logic [CHUNK_W-1:0] m_frame [CHUNKS];
  int               m_ptr;
  bit               m_fv;

  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      m_spk = '0; m_armed = '1; m_win = 0; m_ptr = 0; m_fv = 0;
      for (int j = 0; j < NUM_N; j++) begin m_rf[j] = 0; m_cnt[j] = 0; end
      for (int k = 0; k < CHUNKS; k++) begin m_slot[k] = '0; m_frame[k] = '0; end
    end else begin
      // Winner follows the counts held before this edge: max value, lowest index.
      if (cnt_clr) m_win = 0;
      else begin
        int mx;
        mx = 0;
        for (int j = 0; j < NUM_N; j++) if (m_cnt[j] > mx) mx = m_cnt[j];
        m_win = 0;
        for (int j = NUM_N - 1; j >= 0; j--) if (m_cnt[j] == mx) m_win = j;
      end
      m_spk = '0;
      if (step) begin
        for (int j = 0; j < NUM_N; j++) begin
          if (m_rf[j] > 0) m_rf[j]--;
          else if (m_armed[j] && int'(pot[j]) >= THR_HI) begin
            m_spk[j] = 1'b1; m_armed[j] = 1'b0; m_rf[j] = REFRAC;
          end else if (!m_armed[j] && int'(pot[j]) <= THR_LO) m_armed[j] = 1'b1;
        end
      end
      for (int j = 0; j < NUM_N; j++)
        if (cnt_clr) m_cnt[j] = 0;
        else if (m_spk[j] && m_cnt[j] < 255) m_cnt[j]++;
      m_fv = 0;
      if (bus.in_sync) m_ptr = 0;
      if (bus.in_valid) begin
        m_slot[m_ptr] = bus.in_data;
        if (m_ptr == CHUNKS - 1) begin
          for (int k = 0; k < CHUNKS; k++) m_frame[k] = m_slot[k];
          m_fv = 1; m_ptr = 0;
        end else m_ptr++;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [127:0] exp_cnt;
      exp_cnt = '0;
      for (int j = 0; j < NUM_N; j++) exp_cnt[j*CNT_W +: CNT_W] = 8'(m_cnt[j]);
      check("m_spk", 128'(spk_out), 128'(m_spk));
      check("m_spkblty", 128'(spkblty_out), 128'(m_armed));
      check("m_cnt", cnt_out, exp_cnt);
      check("m_winner", 128'(winner), 128'(m_win));
      check("m_in_ready", 128'(bus.in_ready), 128'(!reset));
      check("m_frame_valid", 128'(frame_valid), 128'(m_fv));
      for (int k = 0; k < CHUNKS; k++)
        check("m_frame_chunk", frame_out[k*CHUNK_W +: CHUNK_W], m_frame[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_step();
    step = 1'b1; tick(); step = 1'b0;
  endtask

  task automatic all_pots(input int v);
    for (int j = 0; j < NUM_N; j++) pot[j] = 8'(v);
  endtask

  task automatic settle();
    all_pots(-5); repeat (3) do_step();
  endtask

  task automatic spike_round(input logic [NUM_N-1:0] mask);
    for (int j = 0; j < NUM_N; j++) pot[j] = mask[j] ? 8'sd70 : -8'sd5;
    do_step();
    all_pots(-5);
    repeat (3) do_step();
  endtask

  task automatic send(input logic [127:0] d, input bit sync);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sync = sync;
    tick();
    bus.in_valid = 1'b0; bus.in_sync = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_sync = 1'b0; bus.in_data = '0;
    all_pots(-5);
    tick(); tick();
    check("rst_in_ready", 128'(bus.in_ready), 128'(0));
    check("rst_spk", 128'(spk_out), 128'(0));
    check("rst_spkblty", 128'(spkblty_out), 128'(16'hffff));
    check("rst_cnt", cnt_out, 128'(0));
    check("rst_winner", 128'(winner), 128'(0));
    reset = 1'b0; tick();
    check("ready_after_rst", 128'(bus.in_ready), 128'(1));

    // Hysteresis on neuron 0 (refractory of 2 steps interleaved)
    pot[0] = 70; do_step();
    check("hy_fire", 128'(spk_out), 128'(16'h0001));
    check("hy_disarm", 128'(spkblty_out), 128'(16'hfffe));
    do_step(); check("hy_refrac1", 128'(spk_out), 128'(0));
    do_step(); do_step();
    check("hy_no_rearm_high", 128'(spkblty_out), 128'(16'hfffe));
    pot[0] = -5; do_step();
    check("hy_rearm", 128'(spkblty_out), 128'(16'hffff));
    check("hy_rearm_nospk", 128'(spk_out), 128'(0));
    pot[0] = 70; do_step();
    check("hy_refire", 128'(spk_out), 128'(16'h0001));
    settle();

    // Refractory window and threshold boundary on neuron 1
    pot[1] = 70; do_step();
    check("rf_fire", 128'(spk_out), 128'(16'h0002));
    pot[1] = -5; do_step(); do_step();
    check("rf_held", 128'(spkblty_out), 128'(16'hfffd));
    do_step();
    check("rf_rearm", 128'(spkblty_out), 128'(16'hffff));
    pot[1] = 63; do_step();
    check("thr_63", 128'(spk_out), 128'(0));
    pot[1] = 64; do_step();
    check("thr_64", 128'(spk_out), 128'(16'h0002));
    settle();

    // Saturating counter and clear priority
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("clr_cnt", cnt_out, 128'(0));
    repeat (300) spike_round(16'h0008);
    check("cnt3_sat", 128'(cnt_out[31:24]), 128'(255));
    pot[3] = 70; step = 1'b1; cnt_clr = 1'b1; tick(); step = 1'b0; cnt_clr = 1'b0;
    check("clr_spk", 128'(spk_out), 128'(16'h0008));
    check("clr_prio", cnt_out, 128'(0));
    settle();

    // Winner tie-break and update latency
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    repeat (5) spike_round(16'h0084);
    repeat (2) spike_round(16'h0008);
    check("win_tie", 128'(winner), 128'(2));
    check("win_n7_cnt", 128'(cnt_out[63:56]), 128'(5));
    pot[7] = 70; do_step(); pot[7] = -5;
    check("win_n7_cnt6", 128'(cnt_out[63:56]), 128'(6));
    check("win_lag", 128'(winner), 128'(2));
    tick();
    check("win_new", 128'(winner), 128'(7));
    settle();

    // Frame load with in_valid toggling
    for (int i = 0; i < CHUNKS; i++) begin
      send(128'(i + 1), 1'b0);
      if (i < CHUNKS - 1) begin
        check("fr_no_pulse", 128'(frame_valid), 128'(0));
        tick();
      end
    end
    check("fr_pulse", 128'(frame_valid), 128'(1));
    check("fr_chunk0", frame_out[127:0], 128'h1);
    check("fr_chunk7", frame_out[1023:896], 128'h8);
    tick();
    check("fr_pulse_end", 128'(frame_valid), 128'(0));

    // Resync alone after a partial frame
    for (int i = 0; i < 3; i++) send(128'(8'hA1 + i), 1'b0);
    bus.in_sync = 1'b1; tick(); bus.in_sync = 1'b0;
    for (int i = 0; i < CHUNKS; i++) send(128'(8'hB1 + i), 1'b0);
    check("sync_pulse", 128'(frame_valid), 128'(1));
    check("sync_chunk0", frame_out[127:0], 128'hB1);
    check("sync_chunk3", frame_out[511:384], 128'hB4);

    // Resync coincident with a transfer
    send(128'hC1, 1'b0); send(128'hC2, 1'b0);
    send(128'hD1, 1'b1);
    for (int i = 1; i < CHUNKS; i++) send(128'(8'hD1 + i), 1'b0);
    check("csync_chunk0", frame_out[127:0], 128'hD1);
    check("csync_chunk7", frame_out[1023:896], 128'hD8);

    // Reset mid-frame and mid-refractory
    pot[0] = 70; do_step(); pot[0] = -5;
    for (int i = 0; i < 5; i++) send(128'(8'hE1 + i), 1'b0);
    reset = 1'b1; tick();
    check("rst_frame_lo", frame_out[127:0], 128'(0));
    check("rst_frame_hi", frame_out[1023:896], 128'(0));
    check("rst_no_pulse", 128'(frame_valid), 128'(0));
    reset = 1'b0; tick();
    pot[0] = 70; do_step(); pot[0] = -5;
    check("rst_refrac_clr", 128'(spk_out), 128'(16'h0001));
    for (int i = 0; i < CHUNKS; i++) send(128'(8'hF1 + i), 1'b0);
    check("rst_ptr0", frame_out[127:0], 128'hF1);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
